// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding and the team NOP payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_FULL  = 2'd1,
    OCC_SKID  = 2'd2
  } occ_e;

  // RISC-V "addi x0, x0, 0", used as FLUSH_VAL for the IF/ID instruction field.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage slot: payload register plus valid bit, with load and clear enables.
module pipe_slot #(
  parameter int unsigned        DATA_W  = 64,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              valid
);

  // Clear wins over load so an emptied slot always reads back as RST_VAL.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q     <= RST_VAL;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush, and optional 1-entry skid slot.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter bit                SKID      = 1'b1,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_e              state_q, state_d;
  logic              main_valid, main_load, main_clr, main_from_skid;
  logic [DATA_W-1:0] main_d, main_q;
  logic              skid_valid, skid_load, skid_clr;
  logic [DATA_W-1:0] skid_q;
  logic              in_xfer, out_xfer;

  assign out_valid = main_valid;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign main_d    = main_from_skid ? skid_q : in_data;

  pipe_slot #(.DATA_W(DATA_W), .RST_VAL(FLUSH_VAL)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .q     (main_q),
    .valid (main_valid)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(.DATA_W(DATA_W), .RST_VAL(FLUSH_VAL)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_data),
        .q     (skid_q),
        .valid (skid_valid)
      );
      // Comes straight from a flop, so upstream never sees out_ready ripple through.
      assign in_ready = !skid_valid;
    end else begin : g_noskid
      assign skid_q     = FLUSH_VAL;
      assign skid_valid = 1'b0;
      assign in_ready   = !main_valid || out_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = OCC_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_xfer) begin
            state_d   = OCC_FULL;
            main_load = 1'b1;
          end
        end
        OCC_FULL: begin
          if (out_xfer && in_xfer) begin
            main_load = 1'b1;
          end else if (out_xfer) begin
            state_d  = OCC_EMPTY;
            main_clr = 1'b1;
          end else if (in_xfer && SKID) begin
            // Main is live and stalled, so the new entry parks behind it.
            state_d   = OCC_SKID;
            skid_load = 1'b1;
          end
        end
        OCC_SKID: begin
          if (out_xfer) begin
            state_d        = OCC_FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = OCC_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

endmodule
